// File: rtl/trap_seq_pkg.sv
// trap_seq_pkg: shared types and vector defaults for the trap sequencer
package trap_seq_pkg;
    typedef enum logic [2:0] {R0, R1, R2, R3, R4, SP, PC, STATUS} reg_e;
    typedef enum logic [2:0] {PASS, ADD, SUB, AND_OP, OR_OP, XOR_OP, SHL, SHR} alu_op_e;
    typedef enum logic {USER, SUPERVISOR} cpu_mode_e;
    typedef enum logic [1:0] {NONE, IRQ, SW, EXC} trap_cause_e;
    typedef enum logic [1:0] {IDLE, PUSH_PC, PUSH_ST, LOAD_VEC} trap_state_e;
    localparam logic [7:0] HW_VEC_BASE_DEF = 8'h10;
    localparam logic [7:0] SW_VEC_DEF = 8'h02;
    localparam logic [7:0] EXC_VEC_DEF = 8'h03;
endpackage

// File: rtl/trap_seq_if.sv
// trap_seq_if: register-file/bus control bundle driven by the trap sequencer
interface trap_seq_if import trap_seq_pkg::*; #(
    parameter int VEC_W = 8
);
    logic wr, pre_dec_sp, oe_a_reg, oe_b_reg, oe_b_consts, oe_alu, ld_reg;
    reg_e sel_a_reg, sel_b_reg, sel_in_reg;
    logic [VEC_W-1:0] const_vec;
    alu_op_e alu_op;
    logic imask_in, ld_imask, ld_mode;
    cpu_mode_e mode_in;
    logic mem_ready;
    modport master (
        output wr, pre_dec_sp, oe_a_reg, oe_b_reg, oe_b_consts, oe_alu, ld_reg,
        output sel_a_reg, sel_b_reg, sel_in_reg, const_vec, alu_op,
        output imask_in, ld_imask, ld_mode, mode_in,
        input  mem_ready
    );
    modport slave (
        input  wr, pre_dec_sp, oe_a_reg, oe_b_reg, oe_b_consts, oe_alu, ld_reg,
        input  sel_a_reg, sel_b_reg, sel_in_reg, const_vec, alu_op,
        input  imask_in, ld_imask, ld_mode, mode_in,
        output mem_ready
    );
endinterface

// File: rtl/trap_seq_irq_arb.sv
// trap_seq_irq_arb: per-line edge/level pending state and lowest-index priority encode
module trap_seq_irq_arb #(
    parameter int N_IRQ = 4,
    parameter logic [N_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             imask,
    input  logic             grant,
    output logic             valid,
    output logic [3:0]       idx,
    output logic [N_IRQ-1:0] ack
);
    logic [N_IRQ-1:0] irq_q, pend_q, pend, qual;
    assign pend = (IRQ_EDGE & pend_q) | (~IRQ_EDGE & irq);
    assign qual = pend & irq_en & {N_IRQ{imask}};
    assign valid = |qual;
    assign ack = grant ? N_IRQ'(1) << idx : '0;
    always_comb begin
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) idx = qual[i] ? 4'(i) : idx;
    end
    // a rising edge coinciding with its own ack keeps the bit set
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            irq_q <= '0;
            pend_q <= '0;
        end else if (en) begin
            irq_q <= irq;
            pend_q <= (irq & ~irq_q) | (pend_q & ~ack);
        end
endmodule

// File: rtl/trap_seq.sv
// trap_seq: arbitrates irq/sw/exception and sequences the PC/STATUS push and vector load
module trap_seq import trap_seq_pkg::*; #(
    parameter int N_IRQ = 4,
    parameter int VEC_W = 8,
    parameter logic [VEC_W-1:0] HW_VEC_BASE = VEC_W'(HW_VEC_BASE_DEF),
    parameter logic [VEC_W-1:0] SW_VEC = VEC_W'(SW_VEC_DEF),
    parameter logic [VEC_W-1:0] EXC_VEC = VEC_W'(EXC_VEC_DEF),
    parameter logic [N_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             boundary,
    input  logic             sw_int,
    input  logic             exception,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             imask,
    output logic             take,
    output logic             busy,
    output logic             done,
    output trap_cause_e      cause,
    output logic [3:0]       irq_id,
    output logic [N_IRQ-1:0] irq_ack,
    trap_seq_if.master       bus
);
    trap_state_e state_q, state_d;
    trap_cause_e cause_d;
    logic first_q, valid, push, push_pc;
    logic [3:0] idx;
    trap_seq_irq_arb #(.N_IRQ(N_IRQ), .IRQ_EDGE(IRQ_EDGE)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .irq    (irq),
        .irq_en (irq_en),
        .imask  (imask),
        .grant  (take && cause_d == IRQ),
        .valid  (valid),
        .idx    (idx),
        .ack    (irq_ack)
    );
    assign cause_d = exception ? EXC : sw_int ? SW : valid ? IRQ : NONE;
    assign take = en && boundary && state_q == IDLE && cause_d != NONE;
    assign busy = en && state_q != IDLE;
    assign push = en && (state_q == PUSH_PC || state_q == PUSH_ST);
    assign push_pc = en && state_q == PUSH_PC && first_q;
    always_comb begin
        state_d = take ? PUSH_PC : state_q;
        state_d = push && bus.mem_ready ? (state_q == PUSH_PC ? PUSH_ST : LOAD_VEC) : state_d;
        state_d = en && state_q == LOAD_VEC ? IDLE : state_d;
        done = en && state_q == LOAD_VEC;
        bus.wr = push;
        bus.pre_dec_sp = push && first_q;
        bus.oe_a_reg = push;
        bus.oe_b_reg = push;
        bus.sel_a_reg = !push ? R0 : state_q == PUSH_PC ? PC : STATUS;
        bus.sel_b_reg = push ? SP : R0;
        bus.imask_in = 1'b0;
        bus.ld_imask = push_pc;
        bus.ld_mode = push_pc;
        bus.mode_in = push_pc ? SUPERVISOR : USER;
        bus.oe_b_consts = done;
        bus.oe_alu = done;
        bus.ld_reg = done;
        bus.alu_op = PASS;
        bus.sel_in_reg = done ? PC : R0;
        bus.const_vec = !done ? '0 : cause == EXC ? EXC_VEC : cause == SW ? SW_VEC :
                        HW_VEC_BASE + VEC_W'(irq_id);
    end
    // first_q marks the first enabled cycle after a state change; it freezes with en
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            cause <= NONE;
            irq_id <= '0;
        end else if (en) begin
            state_q <= state_d;
            first_q <= state_d != state_q;
            if (take) begin
                cause <= cause_d;
                irq_id <= cause_d == IRQ ? idx : 4'd0;
            end
        end
endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: directed vectors against trap_seq with level lines 1..3 and edge line 0
module tb_trap_seq;
    import trap_seq_pkg::*;
    logic clk = 1'b0, rst_n, en, boundary, sw_int, exception, imask;
    logic [3:0] irq, irq_en, irq_id, irq_ack;
    logic take, busy, done;
    trap_cause_e cause;
    int n_chk = 0, n_fail = 0;
    trap_seq_if #(.VEC_W(8)) bus ();
    trap_seq #(.N_IRQ(4), .VEC_W(8), .IRQ_EDGE(4'b0001)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .boundary  (boundary),
        .sw_int    (sw_int),
        .exception (exception),
        .irq       (irq),
        .irq_en    (irq_en),
        .imask     (imask),
        .take      (take),
        .busy      (busy),
        .done      (done),
        .cause     (cause),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .bus       (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int wr_pc, wr_all, pre_pc, done_at, vec_at;
        rst_n = 1'b0; en = 1'b0; boundary = 1'b0; sw_int = 1'b0; exception = 1'b0;
        irq = 4'h0; irq_en = 4'hF; imask = 1'b1; bus.mem_ready = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_wr", 32'(bus.wr), 0);
        check("rst_cause", 32'(cause), 0);
        check("rst_irq_id", 32'(irq_id), 0);
        check("rst_alu_op", 32'(bus.alu_op), 32'(PASS));
        tick(); tick();
        rst_n = 1'b1; en = 1'b1;
        // lowest qualified level line wins
        irq = 4'b0110; boundary = 1'b1; #1;
        check("a_take", 32'(take), 1);
        check("a_ack", 32'(irq_ack), 'h2);
        tick(); boundary = 1'b0; irq = 4'h0; #1;
        check("a_cause", 32'(cause), 1);
        check("a_irq_id", 32'(irq_id), 1);
        check("a_ack_gone", 32'(irq_ack), 0);
        check("a_pc_wr", 32'(bus.wr), 1);
        check("a_pc_pre", 32'(bus.pre_dec_sp), 1);
        check("a_pc_sel_a", 32'(bus.sel_a_reg), 32'(PC));
        check("a_pc_sel_b", 32'(bus.sel_b_reg), 32'(SP));
        check("a_pc_ld_mode", 32'(bus.ld_mode), 1);
        check("a_pc_mode", 32'(bus.mode_in), 32'(SUPERVISOR));
        check("a_pc_ld_imask", 32'(bus.ld_imask), 1);
        tick();
        check("a_st_sel_a", 32'(bus.sel_a_reg), 32'(STATUS));
        check("a_st_pre", 32'(bus.pre_dec_sp), 1);
        check("a_st_ld_imask", 32'(bus.ld_imask), 0);
        tick();
        check("a_lv_done", 32'(done), 1);
        check("a_lv_vec", 32'(bus.const_vec), 'h11);
        check("a_lv_ld_reg", 32'(bus.ld_reg), 1);
        check("a_lv_sel_in", 32'(bus.sel_in_reg), 32'(PC));
        check("a_lv_wr", 32'(bus.wr), 0);
        tick();
        check("a_idle_busy", 32'(busy), 0);
        check("a_idle_done", 32'(done), 0);
        // reset in PUSH_ST with an edge latched on line 0
        sw_int = 1'b1; boundary = 1'b1; #1;
        check("b_take", 32'(take), 1);
        tick(); sw_int = 1'b0; boundary = 1'b0; irq = 4'h1;
        tick(); irq = 4'h0; #1;
        check("b_in_st", 32'(bus.sel_a_reg), 32'(STATUS));
        rst_n = 1'b0; #1;
        check("b_rst_busy", 32'(busy), 0);
        check("b_rst_wr", 32'(bus.wr), 0);
        check("b_rst_cause", 32'(cause), 0);
        tick(); rst_n = 1'b1; boundary = 1'b1; #1;
        check("b_pend_cleared", 32'(take), 0);
        tick(); boundary = 1'b0;
        check("b_idle", 32'(busy), 0);
        // exception beats sw and a fresh edge on line 0; that edge stays pending
        exception = 1'b1; sw_int = 1'b1; irq = 4'h1; boundary = 1'b1; #1;
        check("c_take", 32'(take), 1);
        check("c_ack", 32'(irq_ack), 0);
        tick(); exception = 1'b0; sw_int = 1'b0; boundary = 1'b0; irq = 4'h0; #1;
        check("c_cause", 32'(cause), 3);
        tick(); tick();
        check("c_vec", 32'(bus.const_vec), 'h03);
        check("c_done", 32'(done), 1);
        tick(); boundary = 1'b1; #1;
        check("c_pend_take", 32'(take), 1);
        check("c_pend_ack", 32'(irq_ack), 'h1);
        tick(); boundary = 1'b0; #1;
        check("c_irq_cause", 32'(cause), 1);
        check("c_irq_id", 32'(irq_id), 0);
        tick(); tick();
        check("c_irq_vec", 32'(bus.const_vec), 'h10);
        tick(); boundary = 1'b1; #1;
        check("c_acked", 32'(take), 0);
        boundary = 1'b0;
        // sw ignores imask; masked irqs alone are not taken
        imask = 1'b0; irq = 4'h1; sw_int = 1'b1; boundary = 1'b1; #1;
        check("d_take", 32'(take), 1);
        check("d_ack", 32'(irq_ack), 0);
        tick(); sw_int = 1'b0; boundary = 1'b0; #1;
        check("d_cause", 32'(cause), 2);
        tick(); tick();
        check("d_vec", 32'(bus.const_vec), 'h02);
        tick(); boundary = 1'b1; irq = 4'b0101; #1;
        check("d_masked", 32'(take), 0);
        tick();
        check("d_stay_idle", 32'(busy), 0);
        boundary = 1'b0; irq = 4'h0; imask = 1'b1;
        reset_pulse();
        // two wait states in PUSH_PC
        irq = 4'b1000; boundary = 1'b1; #1;
        check("e_ack", 32'(irq_ack), 'h8);
        bus.mem_ready = 1'b0;
        tick(); boundary = 1'b0; irq = 4'h0;
        wr_pc = 0; wr_all = 0; pre_pc = 0; done_at = 0; vec_at = 0;
        for (int k = 1; k <= 6; k++) begin
            bus.mem_ready = k >= 3; #1;
            if (bus.sel_a_reg == PC) begin
                wr_pc += int'(bus.wr);
                pre_pc += int'(bus.pre_dec_sp);
            end
            wr_all += int'(bus.wr);
            if (done) begin
                done_at = k;
                vec_at = int'(bus.const_vec);
            end
            tick();
        end
        check("e_wr_pc", 32'(wr_pc), 3);
        check("e_wr_all", 32'(wr_all), 4);
        check("e_pre_pc", 32'(pre_pc), 1);
        check("e_done_at", 32'(done_at), 5);
        check("e_vec", 32'(vec_at), 'h13);
        // en low mid-PUSH_PC freezes and resumes without a second pre-decrement
        bus.mem_ready = 1'b0; sw_int = 1'b1; boundary = 1'b1; #1;
        tick(); sw_int = 1'b0; boundary = 1'b0; #1;
        check("g_pre_first", 32'(bus.pre_dec_sp), 1);
        tick();
        check("g_pre_second", 32'(bus.pre_dec_sp), 0);
        en = 1'b0; #1;
        check("g_off_wr", 32'(bus.wr), 0);
        check("g_off_busy", 32'(busy), 0);
        tick(); tick(); en = 1'b1; #1;
        check("g_on_wr", 32'(bus.wr), 1);
        check("g_on_pre", 32'(bus.pre_dec_sp), 0);
        check("g_on_sel_a", 32'(bus.sel_a_reg), 32'(PC));
        bus.mem_ready = 1'b1;
        tick();
        check("g_st_pre", 32'(bus.pre_dec_sp), 1);
        tick(); tick();
        // edge pulse while busy is latched; a re-pulse on its ack keeps it pending
        sw_int = 1'b1; boundary = 1'b1; #1;
        tick(); sw_int = 1'b0; boundary = 1'b0; irq = 4'h1;
        tick(); irq = 4'h0;
        tick(); tick(); boundary = 1'b1; #1;
        check("f_take", 32'(take), 1);
        check("f_ack", 32'(irq_ack), 'h1);
        irq = 4'h1;
        tick(); boundary = 1'b0; irq = 4'h0; #1;
        check("f_id", 32'(irq_id), 0);
        tick(); tick(); tick(); boundary = 1'b1; #1;
        check("f_repend_take", 32'(take), 1);
        check("f_repend_ack", 32'(irq_ack), 'h1);
        tick(); boundary = 1'b0;
        tick(); tick(); tick(); boundary = 1'b1; #1;
        check("f_cleared", 32'(take), 0);
        boundary = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Parametrised trap/interrupt sequencer, the next-generation replacement for the fixed three-state HWINT/SWINT/EXCEPT sequences in the control unit.
- Arbitrates N_IRQ hardware lines (per-line enable, level or edge mode), software interrupt and exception.
- Drives the register-file/bus control signals that push PC and STATUS, enter SUPERVISOR mode and load PC from a per-cause vector.
- Supports memory wait states via mem_ready; the CU hands over the bus at instruction boundaries.

Parameters:
N_IRQ, 4, number of hardware interrupt lines (1..16)
VEC_W, 8, width of vector number driven to the constants unit
HW_VEC_BASE, 8'h10, vector of irq[0]; irq[i] uses HW_VEC_BASE+i
SW_VEC, 8'h02, software interrupt vector
EXC_VEC, 8'h03, exception vector
IRQ_EDGE, {N_IRQ{1'b0}}, per-line mode: 1 = rising-edge latched, 0 = level

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes state and pending bits, forces outputs inactive
boundary  in  1  CU at instruction boundary, offering the bus
sw_int  in  1  software interrupt request (valid with boundary)
exception  in  1  illegal-instruction request (valid with boundary)
irq  in  N_IRQ  hardware request lines
irq_en  in  N_IRQ  per-line enable
imask  in  1  global interrupt enable (status.imask)
mem_ready  in  1  memory write completes this cycle
take  out  1  trap accepted this cycle (combinational)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse in the last sequence cycle
cause  out  2  0 none, 1 irq, 2 sw, 3 exc; registered at take
irq_id  out  4  accepted line index; registered at take
irq_ack  out  N_IRQ  one-hot pulse at take for the accepted line
wr, pre_dec_sp, oe_a_reg, oe_b_reg, oe_b_consts, oe_alu, ld_reg  out  1 each  bus controls
sel_a_reg, sel_b_reg, sel_in_reg  out  reg_e  register selects
const_vec  out  VEC_W  vector number to constants unit
alu_op  out  alu_op_e  ALU operation
imask_in, ld_imask, ld_mode  out  1 each  status writes
mode_in  out  cpu_mode_e  mode to load

Behaviour:
- Reset (rst_n low, any time, including mid-sequence): state IDLE, pending bits 0, edge-detect history 0, cause 0, irq_id 0. Every output is 0 or its enum value 0, and alu_op = PASS.
- Pending, per line i:
  - Edge mode: set on rising edge of irq[i] while en.
  - Level mode: equals irq[i].
  - Qualified = pending[i] & irq_en[i] & imask.
  - Edge pending clears on the irq_ack[i] pulse; an edge arriving in the same cycle as its ack wins, so the bit stays set.
- Arbitration, combinational in IDLE with en & boundary; priority order:
  1. exception
  2. sw_int
  3. lowest-index qualified irq
  - sw_int and exception ignore imask.
  - take = 1 if any cause exists. With no cause, take = 0 and the state is unchanged.
- States and transitions:
  - IDLE -> PUSH_PC on take.
  - PUSH_PC: pre_dec_sp = 1 in the first cycle of the state only; sel_a_reg = PC, oe_a_reg, sel_b_reg = SP, oe_b_reg, wr held.
    - Also in the first cycle only: ld_imask with imask_in = 0, ld_mode with mode_in = SUPERVISOR.
    - Stays in PUSH_PC while !mem_ready; -> PUSH_ST on mem_ready.
  - PUSH_ST: same timing as PUSH_PC with sel_a_reg = STATUS. -> LOAD_VEC on mem_ready.
  - LOAD_VEC (one cycle): oe_b_consts, const_vec = vector of registered cause, alu_op = PASS, oe_alu, sel_in_reg = PC, ld_reg, done = 1. -> IDLE.
- Minimum latency from take to done is 3 cycles; each mem_ready-low cycle adds one.
- busy = 1 in every state except IDLE.
- boundary, sw_int, exception and irq changes are ignored while busy (edge latching continues).
- en low mid-sequence freezes everything and deasserts outputs. Resuming re-enters the same state without re-issuing pre_dec_sp.

Decomposition:
- Add to cu_pkg:
  - trap_cause_e {NONE, IRQ, SW, EXC}
  - trap_state_e {IDLE, PUSH_PC, PUSH_ST, LOAD_VEC}
  - vector constants SW_VEC_DEF, EXC_VEC_DEF
- reg_e, alu_op_e and cpu_mode_e come from reg_pkg and alu_pkg.
- Sub-module irq_arb (parametrised N_IRQ):
  - holds edge detect and pending registers;
  - computes the priority encode;
  - outputs valid, index and ack.

Test Plan:
- Reset mid-PUSH_ST (rst_n low for 1 cycle) -> next cycle state IDLE, busy = 0, wr = 0, all pending cleared.
- irq = 4'b0110, irq_en = 4'hF, imask = 1, boundary pulse, mem_ready = 1 -> take, irq_id = 1, irq_ack = 4'b0010, const_vec = 8'h11 in LOAD_VEC, done 3 cycles after take.
- exception = 1, sw_int = 1, irq[0] = 1 at the same boundary -> cause = 3, const_vec = 8'h03, irq[0] still pending afterwards.
- imask = 0, irq = 4'h1, sw_int = 1 -> sw trap taken with const_vec = 8'h02. Repeat with sw_int = 0 -> take = 0, state stays IDLE.
- mem_ready low for 2 cycles in PUSH_PC -> wr held 3 cycles, pre_dec_sp high exactly 1 cycle, done 5 cycles after take.
- IRQ_EDGE = 4'b0001, single-cycle pulse on irq[0] while busy -> latched; taken at the next boundary. A re-pulse coinciding with its ack -> pending remains 1.
